// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the control sequencer: one-hot state encodings,
// the bit indices the datapath decodes, and the ALU opcodes it acts on.
package ctrl_seq_pkg;

  typedef logic [7:0] state_t;

  typedef enum int unsigned {
    B_FETCH     = 0,
    B_DECODE    = 1,
    B_REG_READ  = 2,
    B_EXECUTE   = 3,
    B_MEMORY    = 4,
    B_REG_WRITE = 5,
    B_HALT      = 6,
    B_FAULT     = 7
  } state_bit_e;

  localparam state_t ST_FETCH     = 8'h01;
  localparam state_t ST_DECODE    = 8'h02;
  localparam state_t ST_REG_READ  = 8'h04;
  localparam state_t ST_EXECUTE   = 8'h08;
  localparam state_t ST_MEMORY    = 8'h10;
  localparam state_t ST_REG_WRITE = 8'h20;
  localparam state_t ST_HALT      = 8'h40;
  localparam state_t ST_FAULT     = 8'h80;

  // ALU opcodes; only READ, WRITE and HALT change sequencing.
  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_READ  = 8;
  localparam int unsigned OP_WRITE = 9;
  localparam int unsigned OP_HALT  = 15;

endpackage

// File: rtl/ctrl_seq_mem_handshake.sv
// Single-request memory handshake shared by FETCH and MEMORY: issue pulse,
// wait flag, completion detect and (with CTRL_TIMEOUT_EN) a wait watchdog.
module ctrl_seq_mem_handshake #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic I_clk,
  input  logic I_reset,
  input  logic req,
  input  logic we,
  input  logic stall,
  input  logic mem_ready,
  input  logic data_ready,
  output logic execute,
  output logic mem_we,
  output logic done,
  output logic timeout
);

  logic wait_q;
  logic exec_q;
  logic we_q;
  logic issue;

  assign issue   = req && !wait_q && mem_ready && !stall;
  // A write completes on mem_ready only after the request pulse has gone.
  assign done    = wait_q && (we_q ? (mem_ready && !exec_q) : data_ready);
  assign execute = exec_q;
  assign mem_we  = we_q;

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      wait_q <= 1'b0;
      exec_q <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      exec_q <= issue;
      if (issue) begin
        wait_q <= 1'b1;
        we_q   <= we;
      end else if (done || timeout) begin
        wait_q <= 1'b0;
      end
    end
  end

`ifdef CTRL_TIMEOUT_EN
  // Count holds the number of wait cycles seen so far, including the current one.
  logic [15:0] cnt_q;

  assign timeout = wait_q && !done && (cnt_q == 16'(TIMEOUT));

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      cnt_q <= '0;
    end else if (issue) begin
      cnt_q <= 16'd1;
    end else if (done || timeout) begin
      cnt_q <= '0;
    end else if (wait_q) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: FETCH/DECODE/REG_READ/EXECUTE/MEMORY/REG_WRITE
// plus terminal HALT and FAULT. Define CTRL_TIMEOUT_EN to enable the memory-wait watchdog.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned OP_LSB   = 12,
  parameter int unsigned OP_W     = 4,
  parameter int unsigned RETIRE_W = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                I_clk,
  input  logic                I_reset,
  input  logic [INSTR_W-1:0]  I_instruction,
  input  logic                I_mem_ready,
  input  logic                I_data_ready,
  input  logic                I_stall,
  output logic [7:0]          O_state,
  output logic                O_execute,
  output logic                O_mem_we,
  output logic [OP_W-1:0]     O_opcode,
  output logic                O_retire,
  output logic [RETIRE_W-1:0] O_retired,
  output logic                O_fault
);

  state_t                state_q;
  state_t                state_d;
  logic [OP_W-1:0]       opcode_q;
  logic [RETIRE_W-1:0]   retired_q;
  logic                  op_read;
  logic                  op_write;
  logic                  op_halt;
  logic                  hs_req;
  logic                  hs_we;
  logic                  hs_done;
  logic                  hs_timeout;
  logic                  retire;
  logic                  unused_instr;

  assign unused_instr = ^I_instruction;

  assign op_read  = (opcode_q == OP_W'(OP_READ));
  assign op_write = (opcode_q == OP_W'(OP_WRITE));
  assign op_halt  = (opcode_q == OP_W'(OP_HALT));

  assign hs_req = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
  assign hs_we  = (state_q == ST_MEMORY) && op_write;

  ctrl_seq_mem_handshake #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_handshake (
    .I_clk      (I_clk),
    .I_reset    (I_reset),
    .req        (hs_req),
    .we         (hs_we),
    .stall      (I_stall),
    .mem_ready  (I_mem_ready),
    .data_ready (I_data_ready),
    .execute    (O_execute),
    .mem_we     (O_mem_we),
    .done       (hs_done),
    .timeout    (hs_timeout)
  );

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (hs_done)         state_d = ST_DECODE;
        else if (hs_timeout) state_d = ST_FAULT;
      end
      ST_DECODE:    if (!I_stall) state_d = op_halt ? ST_HALT : ST_REG_READ;
      ST_REG_READ:  if (!I_stall) state_d = ST_EXECUTE;
      ST_EXECUTE:   if (!I_stall) state_d = (op_read || op_write) ? ST_MEMORY : ST_REG_WRITE;
      ST_MEMORY: begin
        if (hs_done)         state_d = ST_REG_WRITE;
        else if (hs_timeout) state_d = ST_FAULT;
      end
      ST_REG_WRITE: if (!I_stall) state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      ST_FAULT:     state_d = ST_FAULT;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    O_state  = state_q;
    retire   = (state_q == ST_REG_WRITE) && !I_stall;
    O_retire = retire;
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      opcode_q  <= '0;
      retired_q <= '0;
    end else begin
      if ((state_q == ST_FETCH) && hs_done) begin
        opcode_q <= I_instruction[OP_LSB +: OP_W];
      end
      if (retire) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  assign O_opcode  = opcode_q;
  assign O_retired = retired_q;

`ifdef CTRL_TIMEOUT_EN
  assign O_fault = state_q[B_FAULT];
`else
  assign O_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq with RETIRE_W=4 and TIMEOUT=4; watchdog cases
// depend on whether CTRL_TIMEOUT_EN is defined.
module tb_ctrl_seq;

  logic        I_clk = 1'b0;
  logic        I_reset;
  logic [15:0] I_instruction;
  logic        I_mem_ready;
  logic        I_data_ready;
  logic        I_stall;
  logic [7:0]  O_state;
  logic        O_execute;
  logic        O_mem_we;
  logic [3:0]  O_opcode;
  logic        O_retire;
  logic [3:0]  O_retired;
  logic        O_fault;

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_seq #(
    .INSTR_W  (16),
    .OP_LSB   (12),
    .OP_W     (4),
    .RETIRE_W (4),
    .TIMEOUT  (4)
  ) dut (
    .I_clk         (I_clk),
    .I_reset       (I_reset),
    .I_instruction (I_instruction),
    .I_mem_ready   (I_mem_ready),
    .I_data_ready  (I_data_ready),
    .I_stall       (I_stall),
    .O_state       (O_state),
    .O_execute     (O_execute),
    .O_mem_we      (O_mem_we),
    .O_opcode      (O_opcode),
    .O_retire      (O_retire),
    .O_retired     (O_retired),
    .O_fault       (O_fault)
  );

  always #5 I_clk = ~I_clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  // Minimum-latency fetch: issue, completion in the pulse cycle, land in DECODE.
  task automatic do_fetch(input logic [15:0] instr);
    I_mem_ready = 1'b1;
    tick();
    check_val("fetch_pulse", 32'(O_execute), 32'd1);
    I_mem_ready  = 1'b0;
    I_data_ready = 1'b1;
    I_instruction = instr;
    tick();
    I_data_ready = 1'b0;
    check_val("fetch_decode", 32'(O_state), 32'h02);
  endtask

  initial begin
    int pulses;
    I_reset = 1'b1;
    I_instruction = '0;
    I_mem_ready = 1'b0;
    I_data_ready = 1'b0;
    I_stall = 1'b0;
    #12;
    check_val("rst_state", 32'(O_state), 32'h01);
    check_val("rst_exec", 32'(O_execute), 32'd0);
    check_val("rst_we", 32'(O_mem_we), 32'd0);
    check_val("rst_opcode", 32'(O_opcode), 32'd0);
    check_val("rst_retire", 32'(O_retire), 32'd0);
    check_val("rst_retired", 32'(O_retired), 32'd0);
    check_val("rst_fault", 32'(O_fault), 32'd0);
    tick();
    I_reset = 1'b0;
    tick();
    check_val("idle_fetch", 32'(O_state), 32'h01);

    // ADD with data_ready two cycles after the pulse
    I_mem_ready = 1'b1;
    I_instruction = 16'h0123;
    tick();
    check_val("add_pulse", 32'(O_execute), 32'd1);
    check_val("add_pulse_we", 32'(O_mem_we), 32'd0);
    I_mem_ready = 1'b0;
    tick();
    check_val("add_pulse_end", 32'(O_execute), 32'd0);
    check_val("add_wait1", 32'(O_state), 32'h01);
    tick();
    check_val("add_wait2", 32'(O_state), 32'h01);
    I_data_ready = 1'b1;
    tick();
    I_data_ready = 1'b0;
    check_val("add_decode", 32'(O_state), 32'h02);
    check_val("add_opcode", 32'(O_opcode), 32'd0);
    tick();
    check_val("add_rr", 32'(O_state), 32'h04);
    tick();
    check_val("add_ex", 32'(O_state), 32'h08);
    tick();
    check_val("add_rw", 32'(O_state), 32'h20);
    check_val("add_retire", 32'(O_retire), 32'd1);
    tick();
    check_val("add_back", 32'(O_state), 32'h01);
    check_val("add_retire_end", 32'(O_retire), 32'd0);
    check_val("add_retired", 32'(O_retired), 32'd1);

    // READ: second request is a read, held in MEMORY until data_ready
    do_fetch(16'h8000);
    check_val("rd_opcode", 32'(O_opcode), 32'd8);
    tick();
    tick();
    tick();
    check_val("rd_mem", 32'(O_state), 32'h10);
    I_mem_ready = 1'b1;
    tick();
    check_val("rd_pulse", 32'(O_execute), 32'd1);
    check_val("rd_pulse_we", 32'(O_mem_we), 32'd0);
    I_mem_ready = 1'b0;
    tick();
    tick();
    check_val("rd_hold", 32'(O_state), 32'h10);
    check_val("rd_no_pulse", 32'(O_execute), 32'd0);
    I_data_ready = 1'b1;
    tick();
    I_data_ready = 1'b0;
    check_val("rd_rw", 32'(O_state), 32'h20);
    tick();
    check_val("rd_retired", 32'(O_retired), 32'd2);

    // WRITE: mem_ready during the pulse must not complete it
    do_fetch(16'h9000);
    tick();
    tick();
    tick();
    I_mem_ready = 1'b1;
    tick();
    check_val("wr_pulse", 32'(O_execute), 32'd1);
    check_val("wr_pulse_we", 32'(O_mem_we), 32'd1);
    I_data_ready = 1'b1;
    tick();
    I_data_ready = 1'b0;
    check_val("wr_hold", 32'(O_state), 32'h10);
    check_val("wr_no_reissue", 32'(O_execute), 32'd0);
    tick();
    I_mem_ready = 1'b0;
    check_val("wr_rw", 32'(O_state), 32'h20);
    tick();
    check_val("wr_retired", 32'(O_retired), 32'd3);

    // Stall held 5 cycles in REG_READ
    do_fetch(16'h1000);
    tick();
    I_stall = 1'b1;
    I_mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("stall_rr", 32'(O_state), 32'h04);
      check_val("stall_no_exec", 32'(O_execute), 32'd0);
    end
    I_stall = 1'b0;
    I_mem_ready = 1'b0;
    tick();
    check_val("stall_ex", 32'(O_state), 32'h08);
    tick();
    tick();
    check_val("stall_retired", 32'(O_retired), 32'd4);

    // Completion under stall during a fetch wait still reaches DECODE
    I_mem_ready = 1'b1;
    tick();
    I_mem_ready = 1'b0;
    I_stall = 1'b1;
    I_data_ready = 1'b1;
    I_instruction = 16'h2000;
    tick();
    I_data_ready = 1'b0;
    check_val("stallf_decode", 32'(O_state), 32'h02);
    tick();
    check_val("stallf_hold", 32'(O_state), 32'h02);
    I_stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_val("stallf_retired", 32'(O_retired), 32'd5);

    // Retired counter wraps at 16
    for (int i = 0; i < 11; i++) begin
      do_fetch(16'h1000);
      for (int j = 0; j < 4; j++) tick();
    end
    check_val("wrap_zero", 32'(O_retired), 32'd0);
    do_fetch(16'h0000);
    for (int j = 0; j < 4; j++) tick();
    check_val("wrap_one", 32'(O_retired), 32'd1);

    // HALT is terminal and issues nothing
    do_fetch(16'hF000);
    tick();
    check_val("halt_state", 32'(O_state), 32'h40);
    I_mem_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (O_execute) pulses++;
    end
    check_val("halt_pulses", 32'(pulses), 32'd0);
    check_val("halt_stay", 32'(O_state), 32'h40);
    I_mem_ready = 1'b0;
    I_reset = 1'b1;
    #1;
    check_val("halt_reset", 32'(O_state), 32'h01);
    check_val("halt_reset_cnt", 32'(O_retired), 32'd0);
    tick();
    I_reset = 1'b0;
    tick();

    // Reset asserted mid-MEMORY clears everything at once
    do_fetch(16'h0000);
    for (int j = 0; j < 4; j++) tick();
    do_fetch(16'h8000);
    tick();
    tick();
    tick();
    I_mem_ready = 1'b1;
    tick();
    check_val("mr_pulse", 32'(O_execute), 32'd1);
    I_mem_ready = 1'b0;
    #2;
    I_reset = 1'b1;
    #1;
    check_val("mr_state", 32'(O_state), 32'h01);
    check_val("mr_exec", 32'(O_execute), 32'd0);
    check_val("mr_opcode", 32'(O_opcode), 32'd0);
    check_val("mr_retired", 32'(O_retired), 32'd0);
    check_val("mr_we", 32'(O_mem_we), 32'd0);
    I_reset = 1'b0;
    I_data_ready = 1'b1;
    tick();
    I_data_ready = 1'b0;
    check_val("mr_drop", 32'(O_state), 32'h01);

`ifdef CTRL_TIMEOUT_EN
    // Watchdog expiry after 4 wait cycles
    I_mem_ready = 1'b1;
    tick();
    I_mem_ready = 1'b0;
    tick();
    tick();
    tick();
    check_val("wd_wait4", 32'(O_state), 32'h01);
    tick();
    check_val("wd_fault_state", 32'(O_state), 32'h80);
    check_val("wd_fault", 32'(O_fault), 32'd1);
    I_mem_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (O_execute) pulses++;
    end
    check_val("wd_fault_quiet", 32'(pulses), 32'd0);
    I_mem_ready = 1'b0;
    I_reset = 1'b1;
    #1;
    check_val("wd_reset_fault", 32'(O_fault), 32'd0);
    tick();
    I_reset = 1'b0;
    tick();
    // Completion in the expiry cycle wins
    I_mem_ready = 1'b1;
    tick();
    I_mem_ready = 1'b0;
    tick();
    tick();
    tick();
    I_data_ready = 1'b1;
    tick();
    I_data_ready = 1'b0;
    check_val("wd_race_decode", 32'(O_state), 32'h02);
    check_val("wd_race_fault", 32'(O_fault), 32'd0);
`else
    // Without the watchdog a long wait never faults
    I_mem_ready = 1'b1;
    tick();
    I_mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_val("nowd_state", 32'(O_state), 32'h01);
    check_val("nowd_fault", 32'(O_fault), 32'd0);
    I_data_ready = 1'b1;
    tick();
    I_data_ready = 1'b0;
    check_val("nowd_decode", 32'(O_state), 32'h02);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
